alu_control: RTL and testbench

ALU_CONTROL -- requirements
Module: alu_control

---
 rtl/alu_pkg.sv | 94 +++++++++
 rtl/alu_control_if.sv | 25 ++
 rtl/muldiv_engine.sv | 78 +++++++
 rtl/alu_control.sv | 72 +++++++
 tb/tb_alu_control.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encodings, FSM states and opcode decode
package alu_pkg;

    typedef enum logic [3:0] {
        CTL_AND     = 4'b0000,
        CTL_OR      = 4'b0001,
        CTL_ADD     = 4'b0010,
        CTL_XOR     = 4'b0011,
        CTL_SUB     = 4'b0110,
        CTL_SLT     = 4'b0111,
        CTL_SLL     = 4'b1000,
        CTL_SRL     = 4'b1001,
        CTL_SRA     = 4'b1010,
        CTL_LUI     = 4'b1011,
        CTL_NOR     = 4'b1100,
        CTL_PASS_HI = 4'b1101,
        CTL_PASS_LO = 4'b1110
    } alu_ctl_t;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
    typedef enum logic [1:0] {K_ALU, K_ILLEGAL, K_MULDIV} op_kind_t;

    typedef struct packed {
        op_kind_t kind;
        md_op_t   md_op;
        alu_ctl_t ctl;
    } decode_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;

    function automatic decode_t decode(input logic [5:0] alu_op, input logic [5:0] funct);
        decode_t d;
        d.kind  = K_ALU;
        d.md_op = MD_MULT;
        d.ctl   = CTL_ADD;
        if (alu_op == OP_RTYPE) begin
            casez (funct)
                6'b10000?: d.ctl = CTL_ADD;
                6'b10001?: d.ctl = CTL_SUB;
                FN_AND:    d.ctl = CTL_AND;
                FN_OR:     d.ctl = CTL_OR;
                FN_XOR:    d.ctl = CTL_XOR;
                FN_NOR:    d.ctl = CTL_NOR;
                6'b10101?: d.ctl = CTL_SLT;
                FN_SLL:    d.ctl = CTL_SLL;
                FN_SRL:    d.ctl = CTL_SRL;
                FN_SRA:    d.ctl = CTL_SRA;
                FN_MFHI:   d.ctl = CTL_PASS_HI;
                FN_MFLO:   d.ctl = CTL_PASS_LO;
                FN_MULT:   begin d.kind = K_MULDIV; d.md_op = MD_MULT;  end
                FN_MULTU:  begin d.kind = K_MULDIV; d.md_op = MD_MULTU; end
                FN_DIV:    begin d.kind = K_MULDIV; d.md_op = MD_DIV;   end
                FN_DIVU:   begin d.kind = K_MULDIV; d.md_op = MD_DIVU;  end
                default:   d.kind = K_ILLEGAL;
            endcase
        end else begin
            casez (alu_op)
                6'b00100?:    d.ctl = CTL_ADD;
                OP_ANDI:      d.ctl = CTL_AND;
                OP_ORI:       d.ctl = CTL_OR;
                OP_XORI:      d.ctl = CTL_XOR;
                6'b00101?:    d.ctl = CTL_SLT;
                OP_LUI:       d.ctl = CTL_LUI;
                OP_LW, OP_SW: d.ctl = CTL_ADD;
                6'b00010?:    d.ctl = CTL_SUB;
                6'b00001?:    d.ctl = CTL_ADD;
                default:      d.kind = K_ILLEGAL;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_control_if.sv
// rtl/alu_control_if.sv - Control-to-ALU-control bus with master/slave views
interface alu_control_if;
    logic [5:0]  ALUOp;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  ALUCtl;
    logic        ctlValid;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output ALUOp, funct, start, opA, opB,
        input  ALUCtl, ctlValid, busy, done, illegal, HI, LO
    );

    modport slave (
        input  ALUOp, funct, start, opA, opB,
        output ALUCtl, ctlValid, busy, done, illegal, HI, LO
    );
endinterface

// File: rtl/muldiv_engine.sv
// rtl/muldiv_engine.sv - 32-iteration shift-add multiplier / restoring divider
module muldiv_engine
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        run,
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);
    // acc holds {product_hi, multiplier} or {remainder, dividend/quotient}
    logic [63:0] acc, acc_nxt, prod_fix;
    logic [31:0] opnd, mag_a, mag_b, quo_fix, rem_fix;
    logic [32:0] sum, diff;
    logic [5:0]  cnt;
    logic        is_div, neg_main, neg_rem, sgn, div_op;

    assign sgn    = (op == MD_MULT) || (op == MD_DIV);
    assign div_op = (op == MD_DIV) || (op == MD_DIVU);
    assign mag_a  = (sgn && a[31]) ? -a : a;
    assign mag_b  = (sgn && b[31]) ? -b : b;
    assign done   = run && (cnt == 6'd31);

    always_comb begin
        sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        diff = acc[63:31] - {1'b0, opnd};
        if (!is_div)
            acc_nxt = {sum, acc[31:1]};
        else if (!diff[32])
            acc_nxt = {diff[31:0], acc[30:0], 1'b1};
        else
            acc_nxt = {acc[62:0], 1'b0};
        prod_fix = neg_main ? -acc_nxt : acc_nxt;
        quo_fix  = neg_main ? -acc_nxt[31:0] : acc_nxt[31:0];
        rem_fix  = neg_rem ? -acc_nxt[63:32] : acc_nxt[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= 64'd0;
            opnd     <= 32'd0;
            cnt      <= 6'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (start) begin
            cnt      <= 6'd0;
            is_div   <= div_op;
            opnd     <= mag_b;
            acc      <= {32'd0, mag_a};
            neg_main <= sgn && (a[31] ^ b[31]);
            neg_rem  <= sgn && a[31];
            if (div_op && (b == 32'd0)) begin
                hi <= a;
                lo <= 32'hFFFF_FFFF;
            end
        end else if (run) begin
            cnt <= cnt + 6'd1;
            acc <= acc_nxt;
            if (done) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[63:32];
                    lo <= prod_fix[31:0];
                end
            end
        end
    end
endmodule

// File: rtl/alu_control.sv
// rtl/alu_control.sv - ALU operation decode and mult/div sequencing FSM
module alu_control
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu_control_if.slave bus
);
    state_t   state, state_nxt;
    decode_t  dec;
    alu_ctl_t ctl;
    logic     ctl_valid, illegal, eng_start, eng_done, run, is_div;

    assign dec    = decode(bus.ALUOp, bus.funct);
    assign is_div = (dec.md_op == MD_DIV) || (dec.md_op == MD_DIVU);
    assign run    = (state == S_MUL) || (state == S_DIV);

    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        case (state)
            S_IDLE: if (bus.start && dec.kind == K_MULDIV) begin
                eng_start = 1'b1;
                if (!is_div)
                    state_nxt = S_MUL;
                else if (bus.opB == 32'd0)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (eng_done) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ctl       <= CTL_ADD;
            ctl_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctl_valid <= 1'b0;
            illegal   <= 1'b0;
            if (state == S_IDLE && bus.start && dec.kind != K_MULDIV) begin
                ctl       <= dec.ctl;
                ctl_valid <= 1'b1;
                illegal   <= (dec.kind == K_ILLEGAL);
            end
        end
    end

    muldiv_engine u_engine (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .run   (run),
        .op    (dec.md_op),
        .a     (bus.opA),
        .b     (bus.opB),
        .hi    (bus.HI),
        .lo    (bus.LO),
        .done  (eng_done)
    );

    assign bus.ALUCtl   = ctl;
    assign bus.ctlValid = ctl_valid;
    assign bus.illegal  = illegal;
    assign bus.busy     = run;
    assign bus.done     = (state == S_DONE);
endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - directed vectors with a cycle-level reference model
module tb_alu_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   armed = 1'b0;

    alu_control_if bus();

    alu_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference decode. kind: 0 alu op, 1 illegal, 2 MULT, 3 MULTU, 4 DIV, 5 DIVU
    function automatic void mdec(input logic [5:0] op, input logic [5:0] fn,
                                 output int kind, output logic [3:0] ctl);
        kind = 1;
        ctl  = 4'b0010;
        if (op == 6'd0) begin
            if (fn[5:1] == 5'b10000)      begin kind = 0; ctl = 4'b0010; end
            else if (fn[5:1] == 5'b10001) begin kind = 0; ctl = 4'b0110; end
            else if (fn == 6'b100100)     begin kind = 0; ctl = 4'b0000; end
            else if (fn == 6'b100101)     begin kind = 0; ctl = 4'b0001; end
            else if (fn == 6'b100110)     begin kind = 0; ctl = 4'b0011; end
            else if (fn == 6'b100111)     begin kind = 0; ctl = 4'b1100; end
            else if (fn[5:1] == 5'b10101) begin kind = 0; ctl = 4'b0111; end
            else if (fn == 6'b000000)     begin kind = 0; ctl = 4'b1000; end
            else if (fn == 6'b000010)     begin kind = 0; ctl = 4'b1001; end
            else if (fn == 6'b000011)     begin kind = 0; ctl = 4'b1010; end
            else if (fn == 6'b010000)     begin kind = 0; ctl = 4'b1101; end
            else if (fn == 6'b010010)     begin kind = 0; ctl = 4'b1110; end
            else if (fn[5:2] == 4'b0110)  kind = 2 + int'(fn[1:0]);
        end else begin
            if (op[5:1] == 5'b00100 || op == 6'b100011 || op == 6'b101011 || op[5:1] == 5'b00001)
                begin kind = 0; ctl = 4'b0010; end
            else if (op == 6'b001100)     begin kind = 0; ctl = 4'b0000; end
            else if (op == 6'b001101)     begin kind = 0; ctl = 4'b0001; end
            else if (op == 6'b001110)     begin kind = 0; ctl = 4'b0011; end
            else if (op[5:1] == 5'b00101) begin kind = 0; ctl = 4'b0111; end
            else if (op == 6'b001111)     begin kind = 0; ctl = 4'b1011; end
            else if (op[5:1] == 5'b00010) begin kind = 0; ctl = 4'b0110; end
        end
    endfunction

    logic [3:0]  e_ctl;
    logic        e_valid, e_ill, e_busy, e_done;
    logic [31:0] e_hi, e_lo, p_hi, p_lo;
    int          left;

    always @(posedge clk) begin : model
        int          kind;
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [63:0] p;
        longint      q, r;
        if (reset) begin
            e_ctl = 4'b0010; e_valid = 0; e_ill = 0; e_busy = 0; e_done = 0;
            e_hi = 0; e_lo = 0; left = 0;
        end else begin
            e_valid = 0;
            e_ill   = 0;
            if (e_done) begin
                e_done = 0;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    e_busy = 0; e_done = 1; e_hi = p_hi; e_lo = p_lo;
                end
            end else if (bus.start) begin
                mdec(bus.ALUOp, bus.funct, kind, c);
                a = bus.opA;
                b = bus.opB;
                if (kind < 2) begin
                    e_ctl = c; e_valid = 1; e_ill = (kind == 1);
                end else if (kind < 4) begin
                    if (kind == 2) p = longint'($signed(a)) * longint'($signed(b));
                    else           p = {32'd0, a} * {32'd0, b};
                    {p_hi, p_lo} = p;
                    left = 32; e_busy = 1;
                end else if (b == 32'd0) begin
                    e_done = 1; e_hi = a; e_lo = 32'hFFFF_FFFF;
                end else begin
                    if (kind == 4) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    p_lo = q[31:0]; p_hi = r[31:0];
                    left = 32; e_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            cmp("model_ALUCtl",   {28'd0, bus.ALUCtl}, {28'd0, e_ctl});
            cmp("model_ctlValid", {31'd0, bus.ctlValid}, {31'd0, e_valid});
            cmp("model_illegal",  {31'd0, bus.illegal}, {31'd0, e_ill});
            cmp("model_busy",     {31'd0, bus.busy}, {31'd0, e_busy});
            cmp("model_done",     {31'd0, bus.done}, {31'd0, e_done});
            cmp("model_HI",       bus.HI, e_hi);
            cmp("model_LO",       bus.LO, e_lo);
        end
    end

    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp = op; bus.funct = fn; bus.opA = a; bus.opB = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        cmp({tag, "_ALUCtl"},   {28'd0, bus.ALUCtl}, 32'h2);
        cmp({tag, "_ctlValid"}, {31'd0, bus.ctlValid}, 32'd0);
        cmp({tag, "_illegal"},  {31'd0, bus.illegal}, 32'd0);
        cmp({tag, "_busy"},     {31'd0, bus.busy}, 32'd0);
        cmp({tag, "_done"},     {31'd0, bus.done}, 32'd0);
        cmp({tag, "_HI"},       bus.HI, 32'd0);
        cmp({tag, "_LO"},       bus.LO, 32'd0);
    endtask

    // {ALUOp, funct, expected ALUCtl, expected illegal}
    logic [16:0] alu_tbl [13] = '{
        {6'b000000, 6'b100010, 4'b0110, 1'b0},
        {6'b000000, 6'b100001, 4'b0010, 1'b0},
        {6'b000000, 6'b100111, 4'b1100, 1'b0},
        {6'b000000, 6'b101011, 4'b0111, 1'b0},
        {6'b000000, 6'b000011, 4'b1010, 1'b0},
        {6'b000000, 6'b010010, 4'b1110, 1'b0},
        {6'b001111, 6'b101010, 4'b1011, 1'b0},
        {6'b101011, 6'b000000, 4'b0010, 1'b0},
        {6'b000101, 6'b111111, 4'b0110, 1'b0},
        {6'b001101, 6'b000000, 4'b0001, 1'b0},
        {6'b000011, 6'b000000, 4'b0010, 1'b0},
        {6'b111111, 6'b000000, 4'b0010, 1'b1},
        {6'b000000, 6'b000001, 4'b0010, 1'b1}
    };

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a, b, hi, lo;
        int          cycles;
    } md_vec_t;

    md_vec_t md_tbl [9] = '{
        '{6'b011000, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 33},
        '{6'b011001, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 33},
        '{6'b011010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33},
        '{6'b011011, 32'd100,       32'd7,        32'd2,         32'd14,        33},
        '{6'b011011, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1},
        '{6'b011010, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33},
        '{6'b011000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        33},
        '{6'b011010, 32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 1},
        '{6'b011011, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33}
    };

    initial begin : stim
        int n_cyc, n_busy;
        bit seen;
        logic [16:0] v;
        bus.ALUOp = 6'd0; bus.funct = 6'd0; bus.start = 1'b0; bus.opA = 32'd0; bus.opB = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            v = alu_tbl[i];
            issue(v[16:11], v[10:5], 32'h1234_5678, 32'h0000_0010);
            cmp($sformatf("alu%0d_ctl", i),   {28'd0, bus.ALUCtl}, {28'd0, v[4:1]});
            cmp($sformatf("alu%0d_valid", i), {31'd0, bus.ctlValid}, 32'd1);
            cmp($sformatf("alu%0d_ill", i),   {31'd0, bus.illegal}, {31'd0, v[0]});
            cmp($sformatf("alu%0d_busy", i),  {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
            cmp($sformatf("alu%0d_valid_drop", i), {31'd0, bus.ctlValid}, 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            issue(6'd0, md_tbl[i].fn, md_tbl[i].a, md_tbl[i].b);
            n_cyc = 1;
            n_busy = 0;
            while (!bus.done && n_cyc < 80) begin
                if (bus.busy) n_busy++;
                @(negedge clk);
                n_cyc++;
            end
            cmp($sformatf("md%0d_latency", i), n_cyc, md_tbl[i].cycles);
            cmp($sformatf("md%0d_busy_cycles", i), n_busy, (md_tbl[i].cycles == 33) ? 32 : 0);
            cmp($sformatf("md%0d_HI", i), bus.HI, md_tbl[i].hi);
            cmp($sformatf("md%0d_LO", i), bus.LO, md_tbl[i].lo);
            @(negedge clk);
            cmp($sformatf("md%0d_done_drop", i), {31'd0, bus.done}, 32'd0);
        end

        // start arriving while DONE is showing must be dropped
        issue(6'd0, 6'b011011, 32'd9, 32'd0);
        issue(6'd0, 6'b100010, 32'd1, 32'd1);
        cmp("done_start_ignored", {31'd0, bus.ctlValid}, 32'd0);
        @(negedge clk);

        // abort: MULT, ignored ADD at cycle 10, reset (with a competing start) at cycle 20
        issue(6'd0, 6'b011000, 32'h1234_5678, 32'd9);
        repeat (9) @(negedge clk);
        issue(6'd0, 6'b100000, 32'd1, 32'd2);
        cmp("busy_start_ignored", {31'd0, bus.ctlValid}, 32'd0);
        cmp("busy_still", {31'd0, bus.busy}, 32'd1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        bus.ALUOp = 6'd0; bus.funct = 6'b100010; bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        chk_reset_vals("abort");
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        cmp("abort_no_done", {31'd0, seen}, 32'd0);

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_bad++;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
